// File: rtl/flag_cond_unit.sv
// NZVC flag register and decode-stage branch resolver for the pipelined CPU.
// B.cond waits one cycle when the flag-setting instruction is still in EX.
module flag_cond_unit #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_negative,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  input  logic                 alu_carry_out,
  input  logic                 set_flags_ex,
  input  logic                 br_valid,
  input  logic [1:0]           br_type,
  input  logic [3:0]           br_cond,
  input  logic [63:0]          br_reg_data,
  output logic                 br_stall,
  output logic                 br_resolved,
  output logic                 br_taken,
  output logic [3:0]           flags_q,
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] taken_count
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t state, state_next;
  logic   flag_n, flag_z, flag_v, flag_c;
  logic   cond_true;
  logic   eval_taken;

  assign {flag_n, flag_z, flag_v, flag_c} = flags_q;

  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      4'b0000: cond_true = flag_z;
      4'b0001: cond_true = ~flag_z;
      4'b0010: cond_true = flag_c;
      4'b0011: cond_true = ~flag_c;
      4'b0100: cond_true = flag_n;
      4'b0101: cond_true = ~flag_n;
      4'b0110: cond_true = flag_v;
      4'b0111: cond_true = ~flag_v;
      4'b1000: cond_true = flag_c & ~flag_z;
      4'b1001: cond_true = ~(flag_c & ~flag_z);
      4'b1010: cond_true = (flag_n == flag_v);
      4'b1011: cond_true = (flag_n != flag_v);
      4'b1100: cond_true = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_true = ~(~flag_z & (flag_n == flag_v));
      default: cond_true = 1'b1;
    endcase
  end

  always_comb begin
    eval_taken = 1'b0;
    case (br_type)
      2'b00:   eval_taken = cond_true;
      2'b01:   eval_taken = (br_reg_data == '0);
      2'b10:   eval_taken = (br_reg_data != '0);
      default: eval_taken = 1'b1;
    endcase
  end

  always_comb begin
    br_stall    = 1'b0;
    br_resolved = 1'b0;
    br_taken    = 1'b0;
    state_next  = state;
    if (!reset) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (br_valid) begin
            if (br_type == 2'b00 && set_flags_ex) begin
              br_stall   = 1'b1;
              state_next = HOLD;
            end else begin
              br_resolved = 1'b1;
              br_taken    = eval_taken;
            end
          end
        end
        HOLD: begin
          // Flush drops the held branch; another flag write extends the wait.
          if (!br_valid) begin
            state_next = IDLE;
          end else if (set_flags_ex) begin
            br_stall = 1'b1;
          end else begin
            br_resolved = 1'b1;
            br_taken    = eval_taken;
            state_next  = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q <= '0;
    end else if (set_flags_ex) begin
      flags_q <= {alu_negative, alu_zero, alu_overflow, alu_carry_out};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      br_count    <= '0;
      taken_count <= '0;
    end else if (br_resolved) begin
      if (br_count != '1) begin
        br_count <= br_count + CNT_ONE;
      end
      if (br_taken && taken_count != '1) begin
        taken_count <= taken_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_flag_cond_unit.sv
// Randomized scoreboard bench for flag_cond_unit (4-bit counters so saturation is reachable).
module tb_flag_cond_unit;

  localparam int unsigned CW  = 4;
  localparam int          SAT = 15;

  logic          clk;
  logic          reset;
  logic          alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic          set_flags_ex;
  logic          br_valid;
  logic [1:0]    br_type;
  logic [3:0]    br_cond;
  logic [63:0]   br_reg_data;
  logic          br_stall, br_resolved, br_taken;
  logic [3:0]    flags_q;
  logic [CW-1:0] br_count, taken_count;

  flag_cond_unit #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .set_flags_ex(set_flags_ex), .br_valid(br_valid), .br_type(br_type),
    .br_cond(br_cond), .br_reg_data(br_reg_data),
    .br_stall(br_stall), .br_resolved(br_resolved), .br_taken(br_taken),
    .flags_q(flags_q), .br_count(br_count), .taken_count(taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic       res;
    logic       tk;
    logic [3:0] flags;
    int         brc;
    int         tkc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: architectural flags, "a B.cond is waiting", counter values.
  logic [3:0] m_flags   = 4'b0000;
  bit         m_waiting = 0;
  int         m_brc     = 0;
  int         m_tkc     = 0;

  function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, v, c, base;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return cc[0] ? !base : base;
  endfunction

  function automatic logic branch_taken(input logic [1:0] typ, input logic [3:0] cc,
                                        input logic [63:0] data, input logic [3:0] f);
    if (typ == 2'd0) return cond_holds(cc, f);
    if (typ == 2'd1) return data == 64'd0;
    if (typ == 2'd2) return data != 64'd0;
    return 1'b1;
  endfunction

  task automatic step(input logic rst, input logic sf, input logic [3:0] nzvc,
                      input logic valid, input logic [1:0] typ, input logic [3:0] cc,
                      input logic [63:0] data);
    exp_t e;
    @(negedge clk);
    reset = rst; set_flags_ex = sf;
    {alu_negative, alu_zero, alu_overflow, alu_carry_out} = nzvc;
    br_valid = valid; br_type = typ; br_cond = cc; br_reg_data = data;
    e.stall = 1'b0; e.res = 1'b0; e.tk = 1'b0;
    e.flags = m_flags; e.brc = m_brc; e.tkc = m_tkc;
    if (!rst) begin
      m_flags = 4'b0000; m_waiting = 0; m_brc = 0; m_tkc = 0;
    end else begin
      if (valid && !m_waiting && typ == 2'd0 && sf) begin
        e.stall = 1'b1; m_waiting = 1;
      end else if (valid && m_waiting && sf) begin
        e.stall = 1'b1;
      end else if (valid) begin
        e.res = 1'b1; e.tk = branch_taken(typ, cc, data, m_flags); m_waiting = 0;
      end else begin
        m_waiting = 0;
      end
      if (e.res) begin
        m_brc = (m_brc + 1 > SAT) ? SAT : m_brc + 1;
        if (e.tk) m_tkc = (m_tkc + 1 > SAT) ? SAT : m_tkc + 1;
      end
      if (sf) m_flags = nzvc;
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("br_stall",    64'(br_stall),    64'(e.stall));
        chk("br_resolved", 64'(br_resolved), 64'(e.res));
        chk("br_taken",    64'(br_taken),    64'(e.tk));
        chk("flags_q",     64'(flags_q),     64'(e.flags));
        chk("br_count",    64'(br_count),    64'(e.brc));
        chk("taken_count", 64'(taken_count), 64'(e.tkc));
      end
    end
  end

  localparam logic [63:0] BIG = 64'h8000_0000_0000_0000;

  initial begin : driver
    int budget;
    reset = 1'b0; set_flags_ex = 1'b0; br_valid = 1'b0; br_type = 2'd0; br_cond = 4'd0;
    br_reg_data = '0; {alu_negative, alu_zero, alu_overflow, alu_carry_out} = 4'b0000;
    @(posedge clk);
    // Reset with all flags asserted, then B.EQ on cleared flags.
    step(0, 1, 4'b1111, 1, 2'd0, 4'b0000, 0);
    step(0, 1, 4'b1111, 1, 2'd3, 4'b0000, 0);
    step(1, 0, 4'b0000, 1, 2'd0, 4'b0000, 0);
    // SUBS 5-5 with B.EQ behind it.
    step(1, 1, 4'b0101, 1, 2'd0, 4'b0000, 0);
    step(1, 0, 4'b0000, 1, 2'd0, 4'b0000, 0);
    // SUBS max-(-1): N1 Z0 V1 C0, bubble, then GE / LT / LO.
    step(1, 1, 4'b1010, 0, 2'd0, 4'b0000, 0);
    step(1, 0, 4'b0000, 0, 2'd0, 4'b0000, 0);
    step(1, 0, 4'b0000, 1, 2'd0, 4'b1010, 0);
    step(1, 0, 4'b0000, 1, 2'd0, 4'b1011, 0);
    step(1, 0, 4'b0000, 1, 2'd0, 4'b0011, 0);
    // CBZ/CBNZ never stall, even alongside a flag write.
    step(1, 1, 4'b0100, 1, 2'd1, 4'b0000, 0);
    step(1, 1, 4'b0001, 1, 2'd2, 4'b0000, 64'h1);
    step(1, 1, 4'b1000, 1, 2'd1, 4'b0000, BIG);
    // HOLD then flush; HOLD then extended; HOLD then reset.
    step(1, 1, 4'b0100, 1, 2'd0, 4'b0000, 0);
    step(1, 0, 4'b0000, 0, 2'd0, 4'b0000, 0);
    step(1, 1, 4'b0000, 1, 2'd0, 4'b0001, 0);
    step(1, 1, 4'b0100, 1, 2'd0, 4'b0001, 0);
    step(1, 0, 4'b0000, 1, 2'd0, 4'b0001, 0);
    step(1, 1, 4'b1111, 1, 2'd0, 4'b1100, 0);
    step(0, 0, 4'b0000, 1, 2'd0, 4'b1100, 0);
    step(1, 0, 4'b0000, 0, 2'd0, 4'b0000, 0);
    // 20 back-to-back unconditional B: counters saturate at 4'hF.
    for (int i = 0; i < 20; i++) step(1, 0, 4'b0000, 1, 2'd3, 4'b0000, 0);
    step(0, 0, 4'b0000, 0, 2'd0, 4'b0000, 0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] d;
      d = ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom};
      step(($urandom_range(0, 60) != 0), ($urandom_range(0, 2) == 0), 4'($urandom),
           ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3) == 0 ? $urandom : 0),
           4'($urandom), d);
    end
    step(1, 0, 4'b0000, 0, 2'd0, 4'b0000, 0);
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    #4;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
